note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 149 ++++++++++++++
 tb/tb_note_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Note sequencer: records up to eight 4-bit notes and loops them.
// Each step sounds for STEP_TICKS-GAP_TICKS cycles, then is silent.
module note_sequencer #(
    parameter int STEP_TICKS = 16,
    parameter int GAP_TICKS  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] switch,
    input  logic       rec_en,
    input  logic       clear,
    input  logic       play,
    output logic [7:0] frequency_control,
    output logic [2:0] step_idx,
    output logic [3:0] seq_len,
    output logic       playing,
    output logic       gate,
    output logic       step_strobe
);

    typedef enum logic [1:0] {
        IDLE,
        NOTE,
        GAP
    } state_t;

    localparam logic [15:0] NOTE_LAST = 16'(STEP_TICKS - GAP_TICKS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_TICKS - 1);
    localparam bit          HAS_GAP   = (GAP_TICKS > 0);

    state_t      state;
    state_t      state_n;
    logic [15:0] tick;
    logic [15:0] tick_n;
    logic [2:0]  step_n;
    logic [2:0]  step_adv;
    logic        strobe_n;
    logic        last_step;
    logic [3:0]  slots [8];
    logic [2:0]  wr_ptr;
    logic        idle;

    assign idle      = (state == IDLE);
    assign last_step = ({1'b0, step_idx} == (seq_len - 4'd1));
    assign step_adv  = last_step ? 3'd0 : step_idx + 3'd1;

    // Next state, tick and step; stopping drops straight to IDLE.
    always_comb begin
        state_n  = state;
        tick_n   = tick;
        step_n   = step_idx;
        strobe_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (play && (seq_len != 4'd0) && !clear) begin
                    state_n  = NOTE;
                    tick_n   = 16'd0;
                    step_n   = 3'd0;
                    strobe_n = 1'b1;
                end
            end
            NOTE: begin
                if (!play) begin
                    state_n = IDLE;
                    tick_n  = 16'd0;
                    step_n  = 3'd0;
                end else if (tick == NOTE_LAST) begin
                    tick_n = 16'd0;
                    if (HAS_GAP) begin
                        state_n = GAP;
                    end else begin
                        step_n   = step_adv;
                        strobe_n = 1'b1;
                    end
                end else begin
                    tick_n = tick + 16'd1;
                end
            end
            GAP: begin
                if (!play) begin
                    state_n = IDLE;
                    tick_n  = 16'd0;
                    step_n  = 3'd0;
                end else if (tick == GAP_LAST) begin
                    state_n  = NOTE;
                    tick_n   = 16'd0;
                    step_n   = step_adv;
                    strobe_n = 1'b1;
                end else begin
                    tick_n = tick + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                tick_n  = 16'd0;
                step_n  = 3'd0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick     <= 16'd0;
            step_idx <= 3'd0;
        end else begin
            state    <= state_n;
            tick     <= tick_n;
            step_idx <= step_n;
        end
    end

    // Note storage: clear beats record, both only while idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slots   <= '{default: 4'h0};
            wr_ptr  <= 3'd0;
            seq_len <= 4'd0;
        end else if (idle && clear) begin
            wr_ptr  <= 3'd0;
            seq_len <= 4'd0;
        end else if (idle && rec_en && !play) begin
            slots[wr_ptr] <= switch;
            wr_ptr        <= wr_ptr + 3'd1;
            if (seq_len != 4'd8) begin
                seq_len <= seq_len + 4'd1;
            end
        end
    end

    // Registered outputs, derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frequency_control <= 8'h00;
            gate              <= 1'b0;
            playing           <= 1'b0;
            step_strobe       <= 1'b0;
        end else begin
            frequency_control <= (state_n == NOTE) ?
                                 {slots[step_n], 4'h0} : 8'h00;
            gate              <= (state_n == NOTE) &&
                                 (slots[step_n] != 4'h0);
            playing           <= (state_n != IDLE);
            step_strobe       <= strobe_n;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with STEP_TICKS=16, GAP_TICKS=2.
// Table vectors for idle behaviour, hand sequences for playback.
module tb_note_sequencer;

    logic       clk;
    logic       reset_n;
    logic [3:0] switch;
    logic       rec_en;
    logic       clear;
    logic       play;
    logic [7:0] frequency_control;
    logic [2:0] step_idx;
    logic [3:0] seq_len;
    logic       playing;
    logic       gate;
    logic       step_strobe;

    int checks;
    int errors;

    logic [3:0] model [8];
    int         mlen;

    typedef struct {
        logic       rst_n;
        logic [3:0] sw;
        logic       rec;
        logic       clr;
        logic       pl;
        logic [7:0] ef;
        logic       eg;
        logic       es;
        logic       ep;
        logic [3:0] el;
        logic [2:0] ei;
    } vec_t;

    vec_t vecs [10];

    note_sequencer #(
        .STEP_TICKS(16),
        .GAP_TICKS (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .switch           (switch),
        .rec_en           (rec_en),
        .clear            (clear),
        .play             (play),
        .frequency_control(frequency_control),
        .step_idx         (step_idx),
        .seq_len          (seq_len),
        .playing          (playing),
        .gate             (gate),
        .step_strobe      (step_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] ef,
                         input logic eg, input logic es, input logic ep,
                         input logic [3:0] el, input logic [2:0] ei);
        logic [17:0] act;
        logic [17:0] exp;
        act = {frequency_control, gate, step_strobe, playing,
               seq_len, step_idx};
        exp = {ef, eg, es, ep, el, ei};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got freq=%h gate=%b strobe=%b play=%b len=%0d idx=%0d, want freq=%h gate=%b strobe=%b play=%b len=%0d idx=%0d",
                     name, $time, frequency_control, gate, step_strobe,
                     playing, seq_len, step_idx, ef, eg, es, ep, el, ei);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            reset_n = vecs[i].rst_n;
            switch  = vecs[i].sw;
            rec_en  = vecs[i].rec;
            clear   = vecs[i].clr;
            play    = vecs[i].pl;
            tick_clk();
            check($sformatf("vec%0d", i), vecs[i].ef, vecs[i].eg,
                  vecs[i].es, vecs[i].ep, vecs[i].el, vecs[i].ei);
        end
        rec_en = 1'b0;
        clear  = 1'b0;
        play   = 1'b0;
    endtask

    task automatic play_for(input int ncyc, input int pulse_at,
                            input bit rst_end);
        int         s;
        int         t;
        logic [7:0] ef;
        play = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            tick_clk();
            s  = (k / 16) % mlen;
            t  = k % 16;
            ef = (t < 14) ? {model[s], 4'h0} : 8'h00;
            check("play", ef, (t < 14) && (model[s] != 4'h0),
                  t == 0, 1'b1, 4'(mlen), 3'(s));
            rec_en = (k == pulse_at);
            clear  = (k == pulse_at);
            switch = 4'd7;
        end
        rec_en = 1'b0;
        clear  = 1'b0;
        if (rst_end) begin
            reset_n = 1'b0;
            tick_clk();
            check("rst_mid_gap", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
            reset_n = 1'b1;
            mlen    = 0;
            for (int k = 0; k < 3; k++) begin
                tick_clk();
                check("no_restart", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
            end
            play = 1'b0;
        end else begin
            play = 1'b0;
            tick_clk();
            check("stop", 8'h00, 1'b0, 1'b0, 1'b0, 4'(mlen), 3'd0);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        switch  = 4'd0;
        rec_en  = 1'b0;
        clear   = 1'b0;
        play    = 1'b0;

        vecs[0] = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0};
        vecs[1] = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd2, 3'd0};
        vecs[2] = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd3, 3'd0};
        vecs[3] = '{1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd3, 3'd0};
        vecs[4] = '{1'b1, 4'd4, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};
        vecs[5] = '{1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};
        vecs[6] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};
        vecs[7] = '{1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0};
        vecs[8] = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd2, 3'd0};
        vecs[9] = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);

        // Record 1,2,3 and loop them; rec/clear pulse mid-play is ignored.
        apply_vecs(0, 4);
        model = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        mlen  = 3;
        play_for(70, 30, 1'b0);
        play_for(20, -1, 1'b0);

        // Clear beats rec, play on empty stays idle, then record 5,0.
        apply_vecs(4, 9);
        model = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        mlen  = 2;
        play_for(40, -1, 1'b0);

        // Reset during GAP of step 0 with play held high.
        play_for(15, -1, 1'b1);

        // Nine recordings: the ninth overwrites slot 0.
        apply_vecs(9, 10);
        for (int i = 1; i <= 9; i++) begin
            switch = 4'(i);
            rec_en = 1'b1;
            tick_clk();
            rec_en = 1'b0;
            check("rec_nine", 8'h00, 1'b0, 1'b0, 1'b0,
                  (i > 8) ? 4'd8 : 4'(i), 3'd0);
        end
        model = '{4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        mlen  = 8;
        play_for(8 * 16 + 5, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
